div_operand_loader: RTL and testbench
=====================================

Name: div_operand_loader

Overview:
Operand-staging stage that sits directly upstream of the signed divider core. It loads a 32-bit signed dividend (upper and lower halves) and a 16-bit signed divisor from the shared 16-bit databus. On start it converts both operands to unsigned magnitudes and records the result signs. It flags divide-by-zero and quotient overflow before the core runs, then hands the conditioned operands to the core over a valid/ready handshake.

Parameters:
W, 16, databus, divisor and quotient width; dividend width is 2*W.

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  reset, synchronous, active-high
databus  input  W  shared operand bus
ldu  input  1  load dividend upper half from databus
ldl  input  1  load dividend lower half from databus
ldd  input  1  load divisor from databus
st  input  1  start conditioning, single-cycle pulse
dividend_mag  output  2W  unsigned magnitude of the dividend, to the core
divisor_mag  output  W  unsigned magnitude of the divisor, to the core
quo_neg  output  1  quotient sign (dividend sign XOR divisor sign)
rem_neg  output  1  remainder sign (dividend sign)
op_valid  output  1  operands valid for the core
op_ready  input  1  core accepts operands
v  output  1  overflow or divide-by-zero flag, sticky until next accepted st
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, active-high, any state, including mid-operation): state=IDLE; du, dl, dr=0; dividend_mag=0, divisor_mag=0, quo_neg=0, rem_neg=0, op_valid=0, v=0, busy=0. A pending offer is dropped.
- Operand registers du, dl and dr load from databus on a clock edge when the matching ld* input is high and state=IDLE. Any combination of ld* may be asserted in the same cycle. Loads are ignored when busy=1.
- st and ld* asserted in the same IDLE cycle: the registers load, and st is accepted, so conversion uses the newly loaded values (conversion begins on the following cycle).
- st is ignored when busy=1.
- FSM states and transitions:
  - IDLE: on st, clear v and go to CONV.
  - CONV (1 cycle):
    - dividend_mag = {du,dl} if du[W-1]=0, otherwise its two's-complement negation, computed in 2W bits.
    - divisor_mag = dr or -dr, computed in W bits.
    - quo_neg = du[W-1]^dr[W-1]; rem_neg = du[W-1].
    - Go to CHECK.
  - CHECK (1 cycle):
    - ovf = (divisor_mag==0) OR (dividend_mag[2W-1:W-1] >= {1'b0,divisor_mag}), a (W+1)-bit unsigned compare. This conservatively rejects any |quotient| >= 2^(W-1), including a quotient of -2^(W-1).
    - If ovf: v=1, go to IDLE.
    - Otherwise go to OFFER.
  - OFFER:
    - op_valid=1.
    - dividend_mag, divisor_mag, quo_neg and rem_neg are held stable while op_valid=1.
    - On an edge with op_ready=1: op_valid=0, go to IDLE.
    - If op_ready=1 on the first OFFER cycle, the transfer completes in that single cycle.
- Latency: st sampled at edge N gives op_valid=1 after edge N+2, or v=1 after edge N+2 for an overflow case.
- Magnitude edge cases:
  - The most negative dividend 0x80000000 gives magnitude 0x80000000, a valid unsigned value.
  - Divisor 0x8000 gives magnitude 0x8000.
- Outputs are registered and remain at their last values in IDLE. op_valid is the only qualifier for the outputs.
- v stays high through IDLE until the next accepted st.

Test Plan:
- Basic conversion: du=0x0000, dl=0x0064, dr=0xFFF9 (100 / -7), then st → after 2 cycles op_valid=1, dividend_mag=0x00000064, divisor_mag=0x0007, quo_neg=1, rem_neg=0, v=0. With op_ready=1, op_valid drops on the next edge and busy=0.
- Both operands negative: du=0xFFFF, dl=0xFF9C, dr=0xFFF9 (-100 / -7) → dividend_mag=0x64, divisor_mag=7, quo_neg=0, rem_neg=1.
- Divide-by-zero and overflow:
  - dr=0x0000 → v=1 two cycles after st, op_valid never asserts, busy returns to 0.
  - du=0x0001, dl=0x0000, dr=0x0002 → v=1.
  - A following valid st clears v.
- Backpressure: hold op_ready=0 for 3 cycles in OFFER → op_valid and all operand outputs stay stable. Pulse ld*, st and a new databus value during those cycles → no change. Then op_ready=1 → handshake completes.
- Reset mid-operation: assert rst during CONV, and separately during OFFER → on the next edge all outputs are 0 and state=IDLE. A fresh load and st then behaves normally.
- Extreme values: du=0x8000, dl=0x0000, dr=0x8000 → dividend_mag=0x80000000, divisor_mag=0x8000, compare 0x10000 >= 0x8000 → v=1. Separately, dr=0x7FFF with dividend 0x3FFF0000 → 0x7FFE < 0x7FFF → op_valid=1.

Source files
------------

// File: rtl/div_operand_loader_if.sv
// Operand bus between the databus/control side and the divider operand loader.
// The slave side is the loader; the master side drives loads, start and core ready.
interface div_operand_loader_if #(
  parameter int unsigned W = 16
);
  logic [W-1:0]   databus;
  logic           ldu;
  logic           ldl;
  logic           ldd;
  logic           st;
  logic [2*W-1:0] dividend_mag;
  logic [W-1:0]   divisor_mag;
  logic           quo_neg;
  logic           rem_neg;
  logic           op_valid;
  logic           op_ready;
  logic           v;
  logic           busy;

  modport master (
    output databus, ldu, ldl, ldd, st, op_ready,
    input  dividend_mag, divisor_mag, quo_neg, rem_neg, op_valid, v, busy
  );

  modport slave (
    input  databus, ldu, ldl, ldd, st, op_ready,
    output dividend_mag, divisor_mag, quo_neg, rem_neg, op_valid, v, busy
  );
endinterface

// File: rtl/div_operand_loader.sv
// Stages signed dividend/divisor, converts them to magnitudes plus signs,
// screens divide-by-zero/overflow and offers the result to the divider core.
module div_operand_loader #(
  parameter int unsigned W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  div_operand_loader_if.slave  bus
);
  localparam int unsigned DW = 2 * W;

  typedef enum logic [1:0] {IDLE, CONV, CHECK, OFFER} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   du_q, du_d;
  logic [W-1:0]   dl_q, dl_d;
  logic [W-1:0]   dr_q, dr_d;
  logic [DW-1:0]  dvd_mag_q, dvd_mag_d;
  logic [W-1:0]   dvr_mag_q, dvr_mag_d;
  logic           quo_neg_q, quo_neg_d;
  logic           rem_neg_q, rem_neg_d;
  logic           op_valid_q, op_valid_d;
  logic           v_q, v_d;
  logic           busy_q, busy_d;
  logic [DW-1:0]  dvd_raw_c;
  logic           ovf_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      du_q       <= '0;
      dl_q       <= '0;
      dr_q       <= '0;
      dvd_mag_q  <= '0;
      dvr_mag_q  <= '0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      op_valid_q <= 1'b0;
      v_q        <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      du_q       <= du_d;
      dl_q       <= dl_d;
      dr_q       <= dr_d;
      dvd_mag_q  <= dvd_mag_d;
      dvr_mag_q  <= dvr_mag_d;
      quo_neg_q  <= quo_neg_d;
      rem_neg_q  <= rem_neg_d;
      op_valid_q <= op_valid_d;
      v_q        <= v_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    du_d       = du_q;
    dl_d       = dl_q;
    dr_d       = dr_q;
    dvd_mag_d  = dvd_mag_q;
    dvr_mag_d  = dvr_mag_q;
    quo_neg_d  = quo_neg_q;
    rem_neg_d  = rem_neg_q;
    op_valid_d = op_valid_q;
    v_d        = v_q;
    dvd_raw_c  = {du_q, dl_q};
    // Quotient magnitude >= 2^(W-1) is rejected, which also covers -2^(W-1).
    ovf_c      = (dvr_mag_q == '0) ||
                 (dvd_mag_q[DW-1:W-1] >= {1'b0, dvr_mag_q});

    case (state_q)
      IDLE: begin
        if (bus.ldu) du_d = bus.databus;
        if (bus.ldl) dl_d = bus.databus;
        if (bus.ldd) dr_d = bus.databus;
        if (bus.st) begin
          v_d     = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        dvd_mag_d = du_q[W-1] ? (~dvd_raw_c + DW'(1)) : dvd_raw_c;
        dvr_mag_d = dr_q[W-1] ? (~dr_q + W'(1)) : dr_q;
        quo_neg_d = du_q[W-1] ^ dr_q[W-1];
        rem_neg_d = du_q[W-1];
        state_d   = CHECK;
      end
      CHECK: begin
        if (ovf_c) begin
          v_d     = 1'b1;
          state_d = IDLE;
        end else begin
          op_valid_d = 1'b1;
          state_d    = OFFER;
        end
      end
      OFFER: begin
        if (bus.op_ready) begin
          op_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.dividend_mag = dvd_mag_q;
  assign bus.divisor_mag  = dvr_mag_q;
  assign bus.quo_neg      = quo_neg_q;
  assign bus.rem_neg      = rem_neg_q;
  assign bus.op_valid     = op_valid_q;
  assign bus.v            = v_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_div_operand_loader.sv
// Bench for div_operand_loader: directed scenarios plus randomized operands
// compared against a signed-arithmetic reference model.
module tb_div_operand_loader;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  div_operand_loader_if #(.W(16)) bus ();
  div_operand_loader #(.W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Snapshot layout: {op_valid, v, busy, quo_neg, rem_neg, dividend_mag, divisor_mag}
  function automatic logic [52:0] snap();
    return {bus.op_valid, bus.v, bus.busy, bus.quo_neg, bus.rem_neg,
            bus.dividend_mag, bus.divisor_mag};
  endfunction

  function automatic logic [52:0] model(input logic [15:0] du, input logic [15:0] dl,
                                        input logic [15:0] dr);
    longint s, a, d, ad;
    logic   ov;
    s  = longint'($signed({du, dl}));
    a  = (s < 0) ? -s : s;
    d  = longint'($signed(dr));
    ad = (d < 0) ? -d : d;
    ov = (ad == 0) || ((a / ad) >= 32768);
    return {!ov, ov, !ov, (s < 0) != (d < 0), s < 0, 32'(a), 16'(ad)};
  endfunction

  task automatic load_start(input logic [15:0] du, input logic [15:0] dl,
                            input logic [15:0] dr);
    bus.databus = du; bus.ldu = 1'b1;
    tick();
    bus.ldu = 1'b0; bus.databus = dl; bus.ldl = 1'b1;
    tick();
    bus.ldl = 1'b0; bus.databus = dr; bus.ldd = 1'b1; bus.st = 1'b1;
    tick();
    bus.ldd = 1'b0; bus.st = 1'b0; bus.databus = 16'($urandom);
  endtask

  task automatic test_reset();
    logic [52:0] got;
    bus.databus = '0; bus.ldu = 0; bus.ldl = 0; bus.ldd = 0; bus.st = 0; bus.op_ready = 0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    got = snap();
    total++;
    if (got !== 53'd0) begin
      bad++; $display("FAIL reset_state got=%h want=%h", got, 53'd0);
    end
  endtask

  task automatic test_basic();
    logic [52:0] got, exp;
    load_start(16'h0000, 16'h0064, 16'hFFF9);
    tick(); tick();
    got = snap();
    exp = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0064, 16'h0007};
    total++;
    if (got !== exp) begin bad++; $display("FAIL basic_100_m7 got=%h want=%h", got, exp); end
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
    total++;
    if ({bus.op_valid, bus.busy} !== 2'b00) begin
      bad++; $display("FAIL basic_accept got=%b want=00", {bus.op_valid, bus.busy});
    end
    load_start(16'hFFFF, 16'hFF9C, 16'hFFF9);
    tick(); tick();
    got = snap();
    exp = model(16'hFFFF, 16'hFF9C, 16'hFFF9);
    total++;
    if (got !== exp || got[47:0] !== {32'h64, 16'h7}) begin
      bad++; $display("FAIL basic_m100_m7 got=%h want=%h", got, exp);
    end
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [52:0] got, exp;
    load_start(16'h0000, 16'h0000, 16'h0000);
    tick(); tick();
    got = snap();
    exp = model(16'h0000, 16'h0000, 16'h0000);
    total++;
    if (got !== exp || got[51] !== 1'b1) begin
      bad++; $display("FAIL div_by_zero got=%h want=%h", got, exp);
    end
    tick(); tick();
    total++;
    if ({bus.op_valid, bus.v, bus.busy} !== 3'b010) begin
      bad++; $display("FAIL dbz_sticky got=%b want=010", {bus.op_valid, bus.v, bus.busy});
    end
    load_start(16'h0001, 16'h0000, 16'h0002);
    tick(); tick();
    got = snap();
    exp = model(16'h0001, 16'h0000, 16'h0002);
    total++;
    if (got !== exp || got[51] !== 1'b1) begin
      bad++; $display("FAIL overflow_q32768 got=%h want=%h", got, exp);
    end
    load_start(16'h0000, 16'h0064, 16'h0007);
    total++;
    if ({bus.v, bus.busy} !== 2'b01) begin
      bad++; $display("FAIL v_clear_on_st got=%b want=01", {bus.v, bus.busy});
    end
    tick(); tick();
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [52:0] got, exp;
    exp = model(16'h0012, 16'h3456, 16'h0100);
    load_start(16'h0012, 16'h3456, 16'h0100);
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      bus.ldu = 1'b1; bus.ldl = 1'b1; bus.ldd = 1'b1; bus.st = 1'b1;
      bus.databus = 16'($urandom) | 16'h8001;
      got = snap();
      total++;
      if (got !== exp) begin bad++; $display("FAIL hold_%0d got=%h want=%h", i, got, exp); end
      tick();
    end
    bus.ldu = 1'b0; bus.ldl = 1'b0; bus.ldd = 1'b0; bus.st = 1'b0;
    got = snap();
    total++;
    if (got !== exp) begin bad++; $display("FAIL hold_last got=%h want=%h", got, exp); end
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
    total++;
    if ({bus.op_valid, bus.busy} !== 2'b00) begin
      bad++; $display("FAIL bp_accept got=%b want=00", {bus.op_valid, bus.busy});
    end
    // Restart without loads: operands must be those loaded before the stall.
    bus.st = 1'b1;
    tick();
    bus.st = 1'b0;
    tick(); tick();
    got = snap();
    total++;
    if (got !== exp) begin bad++; $display("FAIL loads_ignored got=%h want=%h", got, exp); end
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [52:0] got, exp;
    load_start(16'h0000, 16'h0064, 16'hFFF9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got = snap();
    total++;
    if (got !== 53'd0) begin bad++; $display("FAIL rst_in_conv got=%h want=0", got); end
    load_start(16'h0000, 16'h0064, 16'hFFF9);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got = snap();
    total++;
    if (got !== 53'd0) begin bad++; $display("FAIL rst_in_offer got=%h want=0", got); end
    bus.st = 1'b1;
    tick();
    bus.st = 1'b0;
    tick(); tick();
    got = snap();
    exp = model(16'h0000, 16'h0000, 16'h0000);
    total++;
    if (got !== exp) begin bad++; $display("FAIL rst_clears_ops got=%h want=%h", got, exp); end
    load_start(16'h0000, 16'h0064, 16'hFFF9);
    tick(); tick();
    got = snap();
    exp = model(16'h0000, 16'h0064, 16'hFFF9);
    total++;
    if (got !== exp) begin bad++; $display("FAIL post_rst_op got=%h want=%h", got, exp); end
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
  endtask

  task automatic test_extreme();
    logic [52:0] got, exp;
    load_start(16'h8000, 16'h0000, 16'h8000);
    tick(); tick();
    got = snap();
    exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 16'h8000};
    total++;
    if (got !== exp) begin bad++; $display("FAIL extreme_min got=%h want=%h", got, exp); end
    load_start(16'h3FFF, 16'h0000, 16'h7FFF);
    tick(); tick();
    got = snap();
    exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3FFF_0000, 16'h7FFF};
    total++;
    if (got !== exp) begin bad++; $display("FAIL extreme_edge got=%h want=%h", got, exp); end
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [52:0] got, exp;
    logic [15:0] du, dl, dr;
    int          stall;
    for (int n = 0; n < 60; n++) begin
      dl = 16'($urandom);
      du = ($urandom_range(0, 1) != 0) ? {16{dl[15]}} : 16'($urandom);
      dr = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      exp = model(du, dl, dr);
      load_start(du, dl, dr);
      tick(); tick();
      got = snap();
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL rand_%0d du=%h dl=%h dr=%h got=%h want=%h", n, du, dl, dr, got, exp);
      end
      if (exp[52]) begin
        stall = $urandom_range(0, 3);
        for (int k = 0; k < stall; k++) tick();
        got = snap();
        total++;
        if (got !== exp) begin
          bad++; $display("FAIL rand_hold_%0d got=%h want=%h", n, got, exp);
        end
        bus.op_ready = 1'b1;
        tick();
        bus.op_ready = 1'b0;
        total++;
        if ({bus.op_valid, bus.busy} !== 2'b00) begin
          bad++; $display("FAIL rand_accept_%0d got=%b want=00", n, {bus.op_valid, bus.busy});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_extreme();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
